key_seq_ctrl: RTL and testbench
===============================

# key_seq_ctrl

Key-load and sequencing controller for a key-locked datapath. It receives the obfuscation key serially and holds it in a shadow register. It presents the key to the datapath's `k` input only after the complete key has been captured (and, optionally, checked). It holds the datapath in reset while loading, then releases it and gates its `enable` so the locked logic never runs on a partial or corrupt key.

## Interface
Parameters:
- `KEY_W`, default 14: key width in bits; drives datapath `k[0:KEY_W-1]`.
- `RST_HOLD`, default 4: cycles `dp_rst` stays high after a key is accepted; must be ≥ 1.

Ports:
- `CLK`: in, 1, single clock; all logic on the rising edge.
- `RST_N`: in, 1, asynchronous, active-low reset.
- `key_sdi`: in, 1, serial key bit.
- `key_sdv`: in, 1, `key_sdi` valid qualifier.
- `key_clr`: in, 1, abort or reload request, synchronous.
- `enable_in`: in, 1, system enable request for the datapath.
- `k`: out, `[0:KEY_W-1]`, key to the locked datapath.
- `dp_rst`: out, 1, synchronous active-high reset to the datapath (its `RST`).
- `dp_enable`: out, 1, gated enable to the datapath.
- `key_ready`: out, 1, key loaded and datapath running.
- `key_err`: out, 1, key check failed.

## Operation
- States: IDLE, SHIFT, CHECK, HOLD, RUN, ERROR. Encoding comes from the shared package.
- Reset values (`RST_N` low): state IDLE, `k` = 0, shadow = 0, bit count = 0, `dp_rst` = 1, `dp_enable` = 0, `key_ready` = 0, `key_err` = 0.
- Bit order: the n-th valid bit (n from 0) is written to shadow[n]. The first bit received ends up in `k[0]`.
- IDLE: `dp_rst` = 1.
  - On `key_sdv`, capture the bit into shadow[0], set count = 1, go to SHIFT.
- SHIFT: capture one bit per `key_sdv` cycle. Gaps in `key_sdv` are allowed; the count advances only on valid bits.
  - Once KEY_W bits have been captured (KEY_W + 1 with parity), go to CHECK on the same edge that samples the last bit.
- CHECK: one cycle.
  - Pass: `k` is loaded from shadow and the state goes to HOLD, both on the same edge.
  - Fail: go to ERROR; `k` is unchanged (stays 0).
- HOLD: `dp_rst` = 1 for exactly RST_HOLD cycles, then go to RUN.
- RUN: `dp_rst` = 0, `key_ready` = 1, `dp_enable` = `enable_in` AND (state == RUN).
  - This is combinational from the registered state, with zero added latency.
- ERROR: `key_err` = 1, `dp_rst` = 1, `dp_enable` = 0. The block stays in ERROR until `key_clr`.
- `key_clr` (any state): next state IDLE; `k`, shadow, count and `key_err` are cleared; `dp_rst` = 1.
  - `key_clr` has priority over a simultaneous `key_sdv`, and that bit is dropped.
- `key_sdv` is ignored in CHECK, HOLD, RUN and ERROR. A key is reloaded only via `key_clr`.
- `dp_enable` is 0 in every state except RUN.
- Reset mid-SHIFT: the partial key is discarded and `k` stays 0.

## Timing
- Last key bit sampled at edge E: CHECK during cycle E..E+1, `k` valid after E+1.
- `dp_rst` low and `key_ready` high after edge E+1+RST_HOLD.
- `key_clr` sampled at edge C: `dp_rst` = 1, `key_ready` = 0 and `dp_enable` = 0 after C.
- All outputs except `dp_enable` are registered.

## Configuration
- `KEY_PARITY_EN` defined:
  - SHIFT expects one extra bit after the key: an even-parity bit, so that the XOR of all KEY_W+1 bits is 0.
  - CHECK passes only if that XOR is 0; otherwise the block goes to ERROR.
- `KEY_PARITY_EN` undefined:
  - Exactly KEY_W bits are captured and CHECK always passes.
  - ERROR is unreachable and `key_err` is tied to 0.

## Structure
- Shared package `obfu_pkg`: the state enum, default KEY_W and default RST_HOLD.
- One sub-module, `key_shreg`: shadow register, bit counter, done flag and parity accumulator.
- The FSM, hold counter and output gating live in the top of this block.

## Test plan
All scenarios use KEY_W = 14 and key 10110011100010 (bit0 first).
- Reset, then 14 back-to-back bits -> `k` = 10110011100010 after E+1; `dp_rst` falls after E+5; `key_ready` = 1.
- Same key with `key_sdv` gaps of 3 cycles -> identical `k`; `dp_rst` stays 1 and `k` stays 0 throughout loading.
- In RUN, toggle `enable_in` -> `dp_enable` follows it in the same cycle. In HOLD, `enable_in` = 1 -> `dp_enable` = 0.
- `key_clr` asserted mid-SHIFT, after 7 bits, together with `key_sdv` -> IDLE, count 0; a fresh 14-bit load then succeeds.
- `KEY_PARITY_EN`: parity bit 1 -> RUN. Parity bit 0 -> `key_err` = 1, `k` = 0, `dp_rst` = 1 until `key_clr`.
- Async `RST_N` pulse in RUN -> all outputs return to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/obfu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | obfu_pkg : shared states and defaults for the key sequencing logic    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package obfu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    CHECK = 3'd2,
    HOLD  = 3'd3,
    RUN   = 3'd4,
    ERROR = 3'd5
  } state_e;

  localparam int KEY_W_DEF    = 14;
  localparam int RST_HOLD_DEF = 4;

  // Number of serial bits in one key frame (key plus optional parity bit).
  function automatic int key_bits(input int key_w);
`ifdef KEY_PARITY_EN
    return key_w + 1;
`else
    return key_w;
`endif
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_shreg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | key_shreg : serial key shadow register, bit counter, parity tracker   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module key_shreg
  import obfu_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             cap_i,
  input  logic             sdi_i,
  output logic [0:KEY_W-1] shadow_o,
  output logic             last_o
`ifdef KEY_PARITY_EN
  ,
  output logic             par_ok_o
`endif
);

  localparam int NB = key_bits(KEY_W);
  localparam int CW = $clog2(NB + 1);

  logic [0:KEY_W-1] shadow_q;
  logic [CW-1:0]    cnt_q;
  logic             done_q;
  logic             cap;

  assign cap    = cap_i & ~done_q;
  assign last_o = cap & (cnt_q == CW'(NB - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else if (clr_i) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else if (cap) begin
      // Bit n lands in shadow[n]; the parity bit (index KEY_W) has no slot.
      for (int i = 0; i < KEY_W; i++) begin
        if (cnt_q == CW'(i)) shadow_q[i] <= sdi_i;
      end
      cnt_q <= cnt_q + CW'(1);
      if (last_o) done_q <= 1'b1;
    end
  end

`ifdef KEY_PARITY_EN
  logic par_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      par_q <= 1'b0;
    end else if (clr_i) begin
      par_q <= 1'b0;
    end else if (cap) begin
      par_q <= par_q ^ sdi_i;
    end
  end

  assign par_ok_o = ~par_q;
`endif

  assign shadow_o = shadow_q;

endmodule
`default_nettype wire

// File: rtl/key_seq_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | key_seq_ctrl : key-load / datapath sequencing controller              |
// | Option macro: KEY_PARITY_EN (even-parity bit after the key)           |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module key_seq_ctrl
  import obfu_pkg::*;
#(
  parameter int KEY_W    = KEY_W_DEF,
  parameter int RST_HOLD = RST_HOLD_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             key_sdi,
  input  logic             key_sdv,
  input  logic             key_clr,
  input  logic             enable_in,
  output logic [0:KEY_W-1] k,
  output logic             dp_rst,
  output logic             dp_enable,
  output logic             key_ready,
  output logic             key_err
);

  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
`ifdef KEY_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  state_e           state_q;
  logic [0:KEY_W-1] k_q;
  logic [HW-1:0]    hold_q;
  logic             dp_rst_q;
  logic             key_ready_q;
  logic             key_err_q;

  logic [0:KEY_W-1] shadow;
  logic             shift_last;
  logic             check_pass;
  logic             cap;

  // Serial bits are only accepted while a key frame is being collected.
  assign cap = key_sdv & ~key_clr & ((state_q == IDLE) | (state_q == SHIFT));

  key_shreg #(
    .KEY_W (KEY_W)
  ) u_shreg (
    .clk_i    (CLK),
    .rst_ni   (RST_N),
    .clr_i    (key_clr),
    .cap_i    (cap),
    .sdi_i    (key_sdi),
    .shadow_o (shadow),
    .last_o   (shift_last)
`ifdef KEY_PARITY_EN
    ,
    .par_ok_o (check_pass)
`endif
  );

`ifndef KEY_PARITY_EN
  assign check_pass = 1'b1;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      k_q         <= '0;
      hold_q      <= '0;
      dp_rst_q    <= 1'b1;
      key_ready_q <= 1'b0;
      key_err_q   <= 1'b0;
    end else if (key_clr) begin
      state_q     <= IDLE;
      k_q         <= '0;
      hold_q      <= '0;
      dp_rst_q    <= 1'b1;
      key_ready_q <= 1'b0;
      key_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE:  if (key_sdv) state_q <= shift_last ? CHECK : SHIFT;
        SHIFT: if (shift_last) state_q <= CHECK;
        CHECK: begin
          if (check_pass) begin
            k_q     <= shadow;
            hold_q  <= '0;
            state_q <= HOLD;
          end else begin
            key_err_q <= 1'b1;
            state_q   <= ERROR;
          end
        end
        HOLD: begin
          if (hold_q == HW'(RST_HOLD - 1)) begin
            state_q     <= RUN;
            dp_rst_q    <= 1'b0;
            key_ready_q <= 1'b1;
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        RUN, ERROR: ;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign k         = k_q;
  assign dp_rst    = dp_rst_q;
  assign key_ready = key_ready_q;
  assign key_err   = PAR_EN & key_err_q;
  assign dp_enable = enable_in & (state_q == RUN);

endmodule
`default_nettype wire

// File: tb/tb_key_seq_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_key_seq_ctrl : self-checking bench for key_seq_ctrl                |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_key_seq_ctrl;

  localparam int KW = 14;
  localparam int RH = 4;
`ifdef KEY_PARITY_EN
  localparam int NB  = KW + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int NB  = KW;
  localparam bit PAR = 1'b0;
`endif
  localparam logic [0:KW-1] KEY = 14'b10110011100010;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          key_sdi = 1'b0;
  logic          key_sdv = 1'b0;
  logic          key_clr = 1'b0;
  logic          enable_in = 1'b0;
  logic [0:KW-1] k;
  logic          dp_rst, dp_enable, key_ready, key_err;

  int nchk = 0;
  int nerr = 0;

  key_seq_ctrl #(.KEY_W(KW), .RST_HOLD(RH)) dut (
    .CLK(CLK), .RST_N(RST_N), .key_sdi(key_sdi), .key_sdv(key_sdv),
    .key_clr(key_clr), .enable_in(enable_in), .k(k), .dp_rst(dp_rst),
    .dp_enable(dp_enable), .key_ready(key_ready), .key_err(key_err)
  );

  always #5 CLK = ~CLK;

  // Reference: received bits plus the cycle index at which the frame completed.
  bit mq[$];
  int m_e   = -1;
  int m_cyc = 0;

  function automatic void m_reset();
    mq.delete();
    m_e   = -1;
    m_cyc = 0;
  endfunction

  function automatic void m_edge(bit sdi, bit sdv, bit clr);
    m_cyc++;
    if (clr) begin
      mq.delete();
      m_e = -1;
    end else if (m_e < 0 && sdv) begin
      mq.push_back(sdi);
      if (mq.size() == NB) m_e = m_cyc;
    end
  endfunction

  function automatic bit m_pass();
    bit x = 1'b0;
    foreach (mq[i]) x ^= mq[i];
    return !PAR || (x == 1'b0);
  endfunction

  function automatic bit key_bit(int i);
    return (i < KW) ? KEY[i] : ^KEY;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(string tag, logic [0:KW-1] ek, bit erst, bit een, bit erdy, bit eerr);
    chk({tag, ".k"},         32'(k),         32'(ek));
    chk({tag, ".dp_rst"},    32'(dp_rst),    32'(erst));
    chk({tag, ".dp_enable"}, 32'(dp_enable), 32'(een));
    chk({tag, ".key_ready"}, 32'(key_ready), 32'(erdy));
    chk({tag, ".key_err"},   32'(key_err),   32'(eerr));
  endtask

  task automatic m_check(string tag);
    logic [0:KW-1] ek = '0;
    bit done = (m_e >= 0);
    int age  = m_cyc - m_e;
    bit pass = m_pass();
    bit run;
    if (done && pass && age >= 1)
      for (int i = 0; i < KW; i++) ek[i] = mq[i];
    run = done && pass && (age >= 1 + RH);
    chk_all(tag, ek, !run, run && enable_in, run, done && !pass && age >= 1);
  endtask

  task automatic cyc(bit sdi, bit sdv, bit clr, bit en, string tag);
    key_sdi = sdi; key_sdv = sdv; key_clr = clr; enable_in = en;
    @(posedge CLK);
    m_edge(sdi, sdv, clr);
    #1;
    m_check(tag);
  endtask

  task automatic do_reset();
    key_sdi = 0; key_sdv = 0; key_clr = 0; enable_in = 0;
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk_all("reset", '0, 1'b1, 1'b0, 1'b0, 1'b0);
    RST_N = 1'b1;
    m_reset();
  endtask

  typedef struct {
    bit sdi; bit sdv; bit clr; bit en;
    logic [0:KW-1] k; bit rst; bit dpen; bit rdy;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit sdi, bit sdv, bit clr, bit en,
                              logic [0:KW-1] ek, bit rst, bit dpen, bit rdy);
    vec_t v;
    v.sdi = sdi; v.sdv = sdv; v.clr = clr; v.en = en;
    v.k = ek; v.rst = rst; v.dpen = dpen; v.rdy = rdy;
    tbl.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    // Directed table: back-to-back load, hold window, run with enable toggles, clear.
    for (int i = 0; i < NB; i++) add(key_bit(i), 1, 0, 1, '0, 1, 0, 0);
    add(0, 1, 0, 1, KEY, 1, 0, 0);
    for (int j = 1; j < RH; j++) add(1, 1, 0, 1, KEY, 1, 0, 0);
    add(0, 0, 0, 1, KEY, 0, 1, 1);
    add(0, 0, 0, 0, KEY, 0, 0, 1);
    add(1, 1, 0, 1, KEY, 0, 1, 1);
    add(1, 1, 1, 1, '0, 1, 0, 0);

    do_reset();
    foreach (tbl[i]) begin
      key_sdi = tbl[i].sdi; key_sdv = tbl[i].sdv;
      key_clr = tbl[i].clr; enable_in = tbl[i].en;
      @(posedge CLK);
      m_edge(tbl[i].sdi, tbl[i].sdv, tbl[i].clr);
      #1;
      chk_all($sformatf("vec%0d", i), tbl[i].k, tbl[i].rst, tbl[i].dpen, tbl[i].rdy, 1'b0);
    end

    // Load with 3-cycle gaps; junk on key_sdi while key_sdv is low.
    do_reset();
    for (int i = 0; i < NB; i++) begin
      cyc(key_bit(i), 1, 0, 0, "gap");
      repeat (3) cyc(1'($urandom % 2), 0, 0, 0, "gap");
    end
    repeat (RH) cyc(0, 0, 0, 1, "gap");
    chk("gap.k_final", 32'(k), 32'(KEY));
    chk("gap.ready", 32'(key_ready), 32'd1);
    enable_in = 1'b0; #1;
    chk("run.en_lo", 32'(dp_enable), 32'd0);
    enable_in = 1'b1; #1;
    chk("run.en_hi", 32'(dp_enable), 32'd1);

    // Asynchronous reset while running: outputs drop before any clock edge.
    RST_N = 1'b0; #1;
    chk_all("async", '0, 1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();

    // Clear after 7 bits, coincident with a valid bit, then a fresh load.
    for (int i = 0; i < 7; i++) cyc(key_bit(i), 1, 0, 0, "clr");
    cyc(1, 1, 1, 0, "clr");
    for (int i = 0; i < NB; i++) cyc(key_bit(i), 1, 0, 1, "reload");
    repeat (RH + 1) cyc(0, 0, 0, 1, "reload");
    chk("reload.k", 32'(k), 32'(KEY));
    chk("reload.ready", 32'(key_ready), 32'd1);
    chk("reload.dp_enable", 32'(dp_enable), 32'd1);

`ifdef KEY_PARITY_EN
    // Wrong parity bit: error latched until key_clr.
    do_reset();
    for (int i = 0; i < KW; i++) cyc(key_bit(i), 1, 0, 1, "perr");
    cyc(~key_bit(KW), 1, 0, 1, "perr");
    repeat (RH + 3) cyc(0, 1, 0, 1, "perr");
    chk("perr.err", 32'(key_err), 32'd1);
    chk("perr.k", 32'(k), 32'd0);
    chk("perr.rst", 32'(dp_rst), 32'd1);
    cyc(0, 0, 1, 1, "perr_clr");
    chk("perr_clr.err", 32'(key_err), 32'd0);
`endif

    // Random traffic against the reference.
    do_reset();
    repeat (3000)
      cyc(1'($urandom % 2), ($urandom % 3) != 0, $urandom_range(0, 149) == 0,
          1'($urandom % 2), "rnd");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
